// File: rtl/object_row_scheduler.sv
// Frame sequencer for the scrolling object row: owns the slot/scroll world state,
// walks the object band pixel by pixel and streams plot/x/y/colour to the VGA adapter.
module object_row_scheduler #(
  parameter int SCREEN_W  = 160,
  parameter int Y_TOP     = 60,
  parameter int Y_BOT     = 119,
  parameter int NUM_SLOTS = 11
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_start,
  input  logic       advance,
  input  logic [1:0] new_obj,
  output logic [6:0] obj_y,
  output logic [3:0] obj_distance,
  input  logic [2:0] col_none,
  input  logic [2:0] col_bench,
  input  logic [2:0] col_tree,
  output logic       plot,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       busy,
  output logic       frame_done,
  output logic       new_obj_taken
);

  typedef enum logic [2:0] {IDLE, SCROLL, DRAW, FLUSH, DONE} state_t;

  state_t     state;
  logic       advance_l;
  logic [1:0] new_obj_l;
  logic [3:0] scroll_off;
  logic [1:0] slots [NUM_SLOTS];
  logic [7:0] x_cnt;
  logic [6:0] y_cnt;
  logic [1:0] d_type;

  logic [8:0] world;
  logic [4:0] slot_idx;
  logic [1:0] cur_type;

  // Map the screen column into world space; the slot index never exceeds NUM_SLOTS-1
  always_comb begin
    world    = {1'b0, x_cnt} + {5'b0, scroll_off};
    slot_idx = world[8:4];
    cur_type = 2'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_idx == 5'(i)) cur_type = slots[i];
    end
  end

  assign obj_y        = (state == DRAW) ? y_cnt : 7'd0;
  assign obj_distance = (state == DRAW) ? world[3:0] : 4'd0;

  // Renderers answer one cycle after obj_*, so the colour is picked with the delayed type
  always_comb begin
    case (d_type)
      2'd1:    colour_out = col_bench;
      2'd2:    colour_out = col_tree;
      default: colour_out = col_none;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= IDLE;
      advance_l     <= 1'b0;
      new_obj_l     <= 2'd0;
      scroll_off    <= 4'd0;
      x_cnt         <= 8'd0;
      y_cnt         <= 7'd0;
      d_type        <= 2'd0;
      plot          <= 1'b0;
      x_out         <= 8'd0;
      y_out         <= 7'd0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      new_obj_taken <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= 2'd0;
    end else begin
      plot          <= 1'b0;
      frame_done    <= 1'b0;
      new_obj_taken <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            advance_l <= advance;
            new_obj_l <= new_obj;
            busy      <= 1'b1;
            state     <= SCROLL;
          end
        end
        SCROLL: begin
          if (advance_l) begin
            if (scroll_off == 4'd15) begin
              scroll_off    <= 4'd0;
              new_obj_taken <= 1'b1;
              for (int i = 0; i < NUM_SLOTS - 1; i++) slots[i] <= slots[i+1];
              slots[NUM_SLOTS-1] <= new_obj_l;
            end else begin
              scroll_off <= scroll_off + 4'd1;
            end
          end
          x_cnt <= 8'd0;
          y_cnt <= 7'(Y_TOP);
          state <= DRAW;
        end
        DRAW: begin
          plot   <= 1'b1;
          x_out  <= x_cnt;
          y_out  <= y_cnt;
          d_type <= cur_type;
          if (x_cnt == 8'(SCREEN_W - 1)) begin
            x_cnt <= 8'd0;
            if (y_cnt == 7'(Y_BOT)) state <= FLUSH;
            else                    y_cnt <= y_cnt + 7'd1;
          end else begin
            x_cnt <= x_cnt + 8'd1;
          end
        end
        FLUSH: begin
          frame_done <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
